// File: rtl/cell_truth_checker.sv
// rtl/cell_truth_checker.sv - exhaustive truth-table sweep and checker for a small combinational cell
// Drives every input vector, waits SETTLE cycles, samples the cell output and tallies mismatches.
module cell_truth_checker #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned SETTLE = 2,
  parameter logic [(1 << N_IN)-1:0] TRUTH = 4'b1110
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  output logic [N_IN-1:0] DUT_IN,
  input  logic            DUT_OUT,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN:0]   ERR_CNT,
  output logic [N_IN-1:0] FIRST_FAIL,
  output logic            FAIL_SEEN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_FINISH
  } state_t;

  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
  localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [3:0]      wait_cnt;
  logic            mismatch;

  // Case inequality so an X or Z from the cell is scored as a failure.
  assign mismatch = (DUT_OUT !== TRUTH[vec]);

  assign DUT_IN = vec;
  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_FINISH);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      vec        <= '0;
      wait_cnt   <= '0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FIRST_FAIL <= '0;
      FAIL_SEEN  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            vec        <= '0;
            ERR_CNT    <= '0;
            FIRST_FAIL <= '0;
            FAIL_SEEN  <= 1'b0;
            PASS       <= 1'b0;
            state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (SETTLE > 0) begin
            wait_cnt <= SETTLE_LOAD;
            state    <= S_WAIT;
          end else begin
            state <= S_SAMPLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            ERR_CNT   <= ERR_CNT + 1'b1;
            FAIL_SEEN <= 1'b1;
            if (!FAIL_SEEN) begin
              FIRST_FAIL <= vec;
            end
          end
          if (vec == LAST_VEC) begin
            state <= S_FINISH;
          end else begin
            vec   <= vec + 1'b1;
            state <= S_APPLY;
          end
        end
        S_FINISH: begin
          PASS  <= ~FAIL_SEEN;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_truth_checker.sv
// tb/tb_cell_truth_checker.sv - directed bench for cell_truth_checker
// Three checker instances (defaults, SETTLE=3, N_IN=3) each feed a behavioural cell model.
module tb_cell_truth_checker;

  logic clk;
  logic rst;
  logic start;

  logic [1:0] dut_in_d;
  logic       dut_out_d, busy_d, done_d, pass_d, fs_d;
  logic [2:0] err_d;
  logic [1:0] ff_d;

  logic [1:0] dut_in_s;
  logic       dut_out_s, busy_s, done_s, pass_s, fs_s;
  logic [2:0] err_s;
  logic [1:0] ff_s;

  logic [2:0] dut_in_n;
  logic       dut_out_n, busy_n, done_n, pass_n, fs_n;
  logic [3:0] err_n;
  logic [2:0] ff_n;

  logic [1:0] m_def;
  logic       m_n3;
  logic [3:0] dly_d, dly_s;

  int errors;
  int checks;
  int done_edge [3];
  int done_cnt [3];
  logic [2:0] trace_d [0:31];
  logic [2:0] trace_n [0:31];

  cell_truth_checker u_def (
    .CLK(clk), .RST(rst), .START(start), .DUT_IN(dut_in_d), .DUT_OUT(dut_out_d),
    .BUSY(busy_d), .DONE(done_d), .PASS(pass_d), .ERR_CNT(err_d),
    .FIRST_FAIL(ff_d), .FAIL_SEEN(fs_d)
  );

  cell_truth_checker #(.N_IN(2), .SETTLE(3), .TRUTH(4'b1110)) u_s3 (
    .CLK(clk), .RST(rst), .START(start), .DUT_IN(dut_in_s), .DUT_OUT(dut_out_s),
    .BUSY(busy_s), .DONE(done_s), .PASS(pass_s), .ERR_CNT(err_s),
    .FIRST_FAIL(ff_s), .FAIL_SEEN(fs_s)
  );

  cell_truth_checker #(.N_IN(3), .SETTLE(0), .TRUTH(8'hFE)) u_n3 (
    .CLK(clk), .RST(rst), .START(start), .DUT_IN(dut_in_n), .DUT_OUT(dut_out_n),
    .BUSY(busy_n), .DONE(done_n), .PASS(pass_n), .ERR_CNT(err_n),
    .FIRST_FAIL(ff_n), .FAIL_SEEN(fs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slow OR2: a new input is seen at the output only four edges after DUT_IN changes.
  always @(posedge clk) begin
    dly_d <= {dly_d[2:0], |dut_in_d};
    dly_s <= {dly_s[2:0], |dut_in_s};
  end

  always_comb begin
    dut_out_d = 1'b0;
    case (m_def)
      2'd0:    dut_out_d = |dut_in_d;
      2'd1:    dut_out_d = &dut_in_d;
      2'd2:    dut_out_d = ~|dut_in_d;
      default: dut_out_d = dly_d[3];
    endcase
  end

  assign dut_out_s = dly_s[3];

  always_comb begin
    dut_out_n = |dut_in_n;
    if (m_n3 && dut_in_n == 3'd5) dut_out_n = 1'bx;
  end

  task automatic sweep(input int n_edges);
    for (int i = 0; i < 3; i++) begin
      done_edge[i] = -1;
      done_cnt[i] = 0;
    end
    for (int k = 0; k < n_edges; k++) begin
      start = (k == 0);
      @(negedge clk);
      trace_d[k] = {1'b0, dut_in_d};
      trace_n[k] = dut_in_n;
      if (done_d) begin if (done_edge[0] < 0) done_edge[0] = k; done_cnt[0]++; end
      if (done_s) begin if (done_edge[1] < 0) done_edge[1] = k; done_cnt[1]++; end
      if (done_n) begin if (done_edge[2] < 0) done_edge[2] = k; done_cnt[2]++; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_d); end
    checks++; if (done_d !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_d); end
    checks++; if (pass_d !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass_d); end
    checks++; if (err_d !== 3'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_d); end
    checks++; if (ff_d !== 2'd0) begin errors++; $display("FAIL reset_first_fail got %0d want 0", ff_d); end
    checks++; if (fs_d !== 1'b0) begin errors++; $display("FAIL reset_fail_seen got %b want 0", fs_d); end
    checks++; if (dut_in_d !== 2'd0) begin errors++; $display("FAIL reset_dut_in got %0d want 0", dut_in_d); end
    checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL reset_busy_n3 got %b want 0", busy_n); end
    rst = 1'b0;
  endtask

  task automatic test_or2_pass;
    m_def = 2'd0;
    sweep(20);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (trace_d[k] !== 3'(k / 4)) begin
        errors++; $display("FAIL or2_dut_in edge %0d got %0d want %0d", k, trace_d[k], k / 4);
      end
    end
    checks++; if (done_edge[0] !== 16) begin errors++; $display("FAIL or2_done_edge got %0d want 16", done_edge[0]); end
    checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL or2_done_width got %0d want 1", done_cnt[0]); end
    checks++; if (pass_d !== 1'b1) begin errors++; $display("FAIL or2_pass got %b want 1", pass_d); end
    checks++; if (err_d !== 3'd0) begin errors++; $display("FAIL or2_err_cnt got %0d want 0", err_d); end
    checks++; if (fs_d !== 1'b0) begin errors++; $display("FAIL or2_fail_seen got %b want 0", fs_d); end
    checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL or2_busy_after got %b want 0", busy_d); end
  endtask

  task automatic test_mismatch;
    m_def = 2'd1;
    sweep(20);
    checks++; if (err_d !== 3'd2) begin errors++; $display("FAIL and2_err_cnt got %0d want 2", err_d); end
    checks++; if (ff_d !== 2'd1) begin errors++; $display("FAIL and2_first_fail got %0d want 1", ff_d); end
    checks++; if (pass_d !== 1'b0) begin errors++; $display("FAIL and2_pass got %b want 0", pass_d); end
    checks++; if (fs_d !== 1'b1) begin errors++; $display("FAIL and2_fail_seen got %b want 1", fs_d); end
    checks++; if (done_edge[0] !== 16) begin errors++; $display("FAIL and2_done_edge got %0d want 16", done_edge[0]); end
    m_def = 2'd2;
    sweep(20);
    checks++; if (err_d !== 3'd4) begin errors++; $display("FAIL nor2_err_cnt got %0d want 4", err_d); end
    checks++; if (ff_d !== 2'd0) begin errors++; $display("FAIL nor2_first_fail got %0d want 0", ff_d); end
    checks++; if (pass_d !== 1'b0) begin errors++; $display("FAIL nor2_pass got %b want 0", pass_d); end
  endtask

  task automatic test_settle;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    m_def = 2'd3;
    sweep(26);
    checks++; if (pass_d !== 1'b0) begin errors++; $display("FAIL slow_s2_pass got %b want 0", pass_d); end
    checks++; if (err_d !== 3'd1) begin errors++; $display("FAIL slow_s2_err_cnt got %0d want 1", err_d); end
    checks++; if (ff_d !== 2'd1) begin errors++; $display("FAIL slow_s2_first_fail got %0d want 1", ff_d); end
    checks++; if (done_edge[1] !== 20) begin errors++; $display("FAIL slow_s3_done_edge got %0d want 20", done_edge[1]); end
    checks++; if (pass_s !== 1'b1) begin errors++; $display("FAIL slow_s3_pass got %b want 1", pass_s); end
    checks++; if (err_s !== 3'd0) begin errors++; $display("FAIL slow_s3_err_cnt got %0d want 0", err_s); end
  endtask

  task automatic test_reset_abort;
    int done_seen;
    m_def = 2'd2;
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", busy_d); end
    checks++; if (dut_in_d !== 2'd0) begin errors++; $display("FAIL rst_start_dut_in got %0d want 0", dut_in_d); end
    rst = 1'b0;
    start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 25; k++) begin
      start = (k == 0);
      rst = (k == 7);
      @(negedge clk);
      if (done_d) done_seen++;
      if (k == 6) begin
        checks++; if (err_d !== 3'd1) begin errors++; $display("FAIL abort_pre_err_cnt got %0d want 1", err_d); end
      end
      if (k == 7) begin
        checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_d); end
        checks++; if (dut_in_d !== 2'd0) begin errors++; $display("FAIL abort_dut_in got %0d want 0", dut_in_d); end
        checks++; if (err_d !== 3'd0) begin errors++; $display("FAIL abort_err_cnt got %0d want 0", err_d); end
        checks++; if (fs_d !== 1'b0) begin errors++; $display("FAIL abort_fail_seen got %b want 0", fs_d); end
      end
    end
    rst = 1'b0;
    start = 1'b0;
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
    m_def = 2'd0;
    sweep(20);
    checks++; if (done_edge[0] !== 16) begin errors++; $display("FAIL abort_rerun_done got %0d want 16", done_edge[0]); end
    checks++; if (pass_d !== 1'b1) begin errors++; $display("FAIL abort_rerun_pass got %b want 1", pass_d); end
  endtask

  task automatic test_start_ignored;
    m_def = 2'd1;
    for (int k = 0; k < 19; k++) begin
      start = (k == 0 || k == 3 || k >= 16);
      @(negedge clk);
      if (k == 4) begin
        checks++; if (dut_in_d !== 2'd1) begin errors++; $display("FAIL busy_start_dut_in got %0d want 1", dut_in_d); end
      end
      if (k == 16) begin
        checks++; if (done_d !== 1'b1) begin errors++; $display("FAIL busy_start_done got %b want 1", done_d); end
      end
      if (k == 17) begin
        checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL finish_start_busy got %b want 0", busy_d); end
        checks++; if (err_d !== 3'd2) begin errors++; $display("FAIL finish_start_err_cnt got %0d want 2", err_d); end
      end
      if (k == 18) begin
        checks++; if (busy_d !== 1'b1) begin errors++; $display("FAIL held_start_busy got %b want 1", busy_d); end
        checks++; if (err_d !== 3'd0) begin errors++; $display("FAIL held_start_err_cnt got %0d want 0", err_d); end
        checks++; if (fs_d !== 1'b0) begin errors++; $display("FAIL held_start_fail_seen got %b want 0", fs_d); end
      end
    end
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_n_in3;
    m_n3 = 1'b0;
    sweep(20);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (trace_n[k] !== 3'(k / 2)) begin
        errors++; $display("FAIL or3_dut_in edge %0d got %0d want %0d", k, trace_n[k], k / 2);
      end
    end
    checks++; if (done_edge[2] !== 16) begin errors++; $display("FAIL or3_done_edge got %0d want 16", done_edge[2]); end
    checks++; if (pass_n !== 1'b1) begin errors++; $display("FAIL or3_pass got %b want 1", pass_n); end
    m_n3 = 1'b1;
    sweep(20);
    checks++; if (err_n !== 4'd1) begin errors++; $display("FAIL or3_x_err_cnt got %0d want 1", err_n); end
    checks++; if (ff_n !== 3'd5) begin errors++; $display("FAIL or3_x_first_fail got %0d want 5", ff_n); end
    checks++; if (pass_n !== 1'b0) begin errors++; $display("FAIL or3_x_pass got %b want 0", pass_n); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    m_def = 2'd0;
    m_n3 = 1'b0;
    test_reset;
    test_or2_pass;
    test_mismatch;
    test_settle;
    test_reset_abort;
    test_start_ignored;
    test_n_in3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
